// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential ROM reads, tagged prefetch FIFO, ARM condition verdict.
// Optional macro FETCH_SKIP_FAILED_EN drops condition-failed head entries instead of presenting them.
module fetch_prefetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter int                MEM_LAT    = 1,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          mem_rd,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          redirect,
    input  logic [1:0]                    pc_s,
    input  logic [ADDR_W-1:0]             pc_b_out,
    input  logic [ADDR_W-1:0]             pc_f_out,
    input  logic [3:0]                    NZCV,
    input  logic                          ir_ready,
    output logic                          ir_valid,
    output logic [DATA_W-1:0]             IR,
    output logic [ADDR_W-1:0]             IR_pc,
    output logic                          cond_pass,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [MEM_LAT-1:0] r_tag_vld;
    logic [ADDR_W-1:0] r_tag_pc [MEM_LAT];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [OCC_W-1:0]  w_inflight;
    logic [OCC_W-1:0]  w_occupied;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_head_present;
    logic              w_valid;
    logic              w_cond;
    logic [DATA_W-1:0] w_head_ir;
    logic [ADDR_W-1:0] w_head_pc;
    logic [ADDR_W-1:0] w_target;

    function automatic logic f_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Credits cover both buffered and in-flight words, so a returning word always finds a free slot.
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < MEM_LAT; k++) begin
            w_inflight = w_inflight + {{(OCC_W-1){1'b0}}, r_tag_vld[k]};
        end
        w_occupied = {1'b0, r_count} + w_inflight;
    end

    assign w_issue        = !rst && !redirect && (w_occupied < OCC_W'(FIFO_DEPTH));
    assign w_push         = r_tag_vld[MEM_LAT-1] && !redirect;
    assign w_head_present = (r_count != '0);
    assign w_head_ir      = w_head_present ? r_fifo_data[r_rd_ptr] : '0;
    assign w_head_pc      = w_head_present ? r_fifo_pc[r_rd_ptr] : '0;
    assign w_cond         = f_cond(w_head_ir[DATA_W-1 -: 4], NZCV);

    // ir_valid/ir_ready: the head entry moves to decode on a falling edge where both are high;
    // ir_valid never depends on ir_ready, and a redirect on that edge cancels the transfer.
`ifdef FETCH_SKIP_FAILED_EN
    assign w_valid = w_head_present && w_cond;
    assign w_pop   = !redirect && w_head_present && (!w_cond || ir_ready);
`else
    assign w_valid = w_head_present;
    assign w_pop   = !redirect && w_head_present && ir_ready;
`endif

    always_comb begin
        case (pc_s)
            2'b00:   w_target = r_pc + ADDR_W'(4);
            2'b01:   w_target = pc_b_out;
            2'b10:   w_target = pc_f_out;
            default: w_target = RESET_PC;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_tag_vld <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (redirect) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(4);
            end
            r_tag_vld[0] <= w_issue;
            for (int k = 1; k < MEM_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1] && !redirect;
            end
            if (redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload storage needs no reset: occupancy and tag-valid bits qualify every entry.
    always_ff @(negedge clk) begin
        r_tag_pc[0] <= r_pc;
        for (int k = 1; k < MEM_LAT; k++) begin
            r_tag_pc[k] <= r_tag_pc[k-1];
        end
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_tag_pc[MEM_LAT-1];
        end
    end

    assign mem_rd     = w_issue;
    assign mem_addr   = r_pc;
    assign ir_valid   = w_valid;
    assign IR         = w_valid ? w_head_ir : '0;
    assign IR_pc      = w_valid ? w_head_pc : '0;
    assign cond_pass  = w_cond;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: one instance with MEM_LAT=1, one with MEM_LAT=2.
module tb_fetch_prefetch_unit;
  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [1:0]  pc_s = 2'b00;
  logic [31:0] pc_b_out = '0;
  logic [31:0] pc_f_out = '0;
  logic [3:0]  nzcv = 4'b0100;
  logic        ir_ready = 1'b0;

  logic        mem_rd, ir_valid, cond_pass;
  logic [31:0] mem_addr, mem_rdata, ir, ir_pc;
  logic [2:0]  fifo_count;

  logic        mem_rd_b, ir_valid_b, cond_pass_b;
  logic [31:0] mem_addr_b, mem_rdata_b, ir_b, ir_pc_b, rom_b_p0;
  logic [2:0]  fifo_count_b;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .MEM_LAT(1), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect(redirect), .pc_s(pc_s), .pc_b_out(pc_b_out), .pc_f_out(pc_f_out), .NZCV(nzcv),
    .ir_ready(ir_ready), .ir_valid(ir_valid), .IR(ir), .IR_pc(ir_pc), .cond_pass(cond_pass),
    .fifo_count(fifo_count)
  );

  fetch_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .MEM_LAT(2), .RESET_PC(32'h0)) u_dut_b (
    .clk(clk), .rst(rst), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .redirect(redirect), .pc_s(pc_s), .pc_b_out(pc_b_out), .pc_f_out(pc_f_out), .NZCV(nzcv),
    .ir_ready(ir_ready), .ir_valid(ir_valid_b), .IR(ir_b), .IR_pc(ir_pc_b), .cond_pass(cond_pass_b),
    .fifo_count(fifo_count_b)
  );

  // ROM image: words in 0x2xx carry condition GT (0xC), all others AL (0xE).
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a[11:8] == 4'h2) return 32'hC000_0000 + (a >> 2);
    return 32'hE000_0000 + (a >> 2);
  endfunction

  always @(negedge clk) mem_rdata <= mem_rd ? rom(mem_addr) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    rom_b_p0    <= mem_rd_b ? rom(mem_addr_b) : 32'hDEAD_BEEF;
    mem_rdata_b <= rom_b_p0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid got=%0h exp=0", ir_valid); end
    n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    n_tests++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got=%0h exp=0", mem_rd); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    n_tests++; if (ir !== 32'h0 || ir_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ir got=%0h/%0h exp=0/0", ir, ir_pc); end
    n_tests++; if (cond_pass !== 1'b1) begin n_fail++; $display("FAIL reset_cond_z1 got=%0h exp=1", cond_pass); end
    nzcv = 4'b0000;
    #1;
    n_tests++; if (cond_pass !== 1'b0) begin n_fail++; $display("FAIL reset_cond_z0 got=%0h exp=0", cond_pass); end
  endtask

  task automatic test_fill();
    rst = 1'b0;
    ir_ready = 1'b1;
    step();
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL fill_first_edge_valid got=%0h exp=0", ir_valid); end
    n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL fill_issue got=%0h/%0h exp=1/4", mem_rd, mem_addr); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_tests++;
      if (ir_valid !== 1'b1 || ir_pc !== 32'(4 * k) || ir !== 32'hE000_0000 + 32'(k) || fifo_count !== 3'd1) begin
        n_fail++;
        $display("FAIL fill_stream k=%0d got v=%0h pc=%0h ir=%0h cnt=%0d exp v=1 pc=%0h ir=%0h cnt=1",
                 k, ir_valid, ir_pc, ir, fifo_count, 4 * k, 32'hE000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    ir_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_saturate got=%0d exp=4", fifo_count); end
    n_tests++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_mem_rd got=%0h exp=0", mem_rd); end
    n_tests++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head got=%0h/%0h exp=1/0", ir_valid, ir_pc); end
    ir_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_tests++;
      if (ir_valid !== 1'b1 || ir_pc !== 32'(4 * (k + 1))) begin
        n_fail++;
        $display("FAIL bp_release k=%0d got v=%0h pc=%0h exp v=1 pc=%0h", k, ir_valid, ir_pc, 4 * (k + 1));
      end
    end
  endtask

  task automatic test_same_edge_redirect_pop();
    ir_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    n_tests++; if (ir_valid !== 1'b1 || ir_pc !== 32'h8) begin n_fail++; $display("FAIL sep_head got=%0h/%0h exp=1/8", ir_valid, ir_pc); end
    redirect = 1'b1;
    pc_s = 2'b10;
    pc_f_out = 32'h100;
    step();
    n_tests++; if (fifo_count !== 3'd0 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL sep_flush got cnt=%0d v=%0h exp cnt=0 v=0", fifo_count, ir_valid); end
    n_tests++; if (mem_addr !== 32'h100 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL sep_pc got=%0h/%0h exp=100/0", mem_addr, mem_rd); end
    redirect = 1'b0;
    step();
    n_tests++; if (ir_valid !== 1'b0 || mem_addr !== 32'h104) begin n_fail++; $display("FAIL sep_e1 got v=%0h addr=%0h exp v=0 addr=104", ir_valid, mem_addr); end
    step();
    n_tests++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h100 || ir !== 32'hE000_0040) begin
      n_fail++; $display("FAIL sep_new_head got v=%0h pc=%0h ir=%0h exp v=1 pc=100 ir=e0000040", ir_valid, ir_pc, ir);
    end
  endtask

  task automatic test_redirect_flush();
    ir_ready = 1'b1;
    do_reset();
    step();
    step();
    n_tests++; if (fifo_count_b !== 3'd0 || ir_valid_b !== 1'b0) begin n_fail++; $display("FAIL rf_pre got cnt=%0d v=%0h exp 0/0", fifo_count_b, ir_valid_b); end
    redirect = 1'b1;
    pc_s = 2'b01;
    pc_b_out = 32'h40;
    step();
    n_tests++; if (mem_addr_b !== 32'h40 || fifo_count_b !== 3'd0) begin n_fail++; $display("FAIL rf_pc got addr=%0h cnt=%0d exp 40/0", mem_addr_b, fifo_count_b); end
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++; if (ir_valid_b !== 1'b0) begin n_fail++; $display("FAIL rf_stale i=%0d got v=%0h pc=%0h exp v=0", i, ir_valid_b, ir_pc_b); end
    end
    step();
    n_tests++;
    if (ir_valid_b !== 1'b1 || ir_pc_b !== 32'h40 || ir_b !== 32'hE000_0010) begin
      n_fail++; $display("FAIL rf_first got v=%0h pc=%0h ir=%0h exp v=1 pc=40 ir=e0000010", ir_valid_b, ir_pc_b, ir_b);
    end
    step();
    n_tests++; if (ir_valid_b !== 1'b1 || ir_pc_b !== 32'h44) begin n_fail++; $display("FAIL rf_second got v=%0h pc=%0h exp v=1 pc=44", ir_valid_b, ir_pc_b); end
  endtask

  task automatic test_back_to_back_redirect();
    ir_ready = 1'b1;
    redirect = 1'b1;
    pc_s = 2'b11;
    step();
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL b2b_reset_pc got=%0h exp=0", mem_addr); end
    pc_s = 2'b10;
    pc_f_out = 32'h300;
    step();
    n_tests++; if (mem_addr !== 32'h300 || fifo_count !== 3'd0 || ir_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second got addr=%0h cnt=%0d v=%0h exp 300/0/0", mem_addr, fifo_count, ir_valid);
    end
    redirect = 1'b0;
    step();
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got v=%0h pc=%0h exp v=0", ir_valid, ir_pc); end
    step();
    n_tests++; if (ir_valid !== 1'b1 || ir_pc !== 32'h300 || ir !== 32'hE000_00C0) begin
      n_fail++; $display("FAIL b2b_head got v=%0h pc=%0h ir=%0h exp v=1 pc=300 ir=e00000c0", ir_valid, ir_pc, ir);
    end
    redirect = 1'b1;
    pc_s = 2'b00;
    step();
    n_tests++; if (mem_addr !== 32'h30C) begin n_fail++; $display("FAIL b2b_pc_plus4 got=%0h exp=30c", mem_addr); end
    redirect = 1'b0;
  endtask

  task automatic test_conditions();
    nzcv = 4'b0000;
    ir_ready = 1'b0;
    do_reset();
    redirect = 1'b1;
    pc_s = 2'b01;
    pc_b_out = 32'h200;
    step();
    redirect = 1'b0;
    step();
    step();
    n_tests++; if (ir_valid !== 1'b1 || ir_pc !== 32'h200 || ir !== 32'hC000_0080 || cond_pass !== 1'b1) begin
      n_fail++; $display("FAIL cond_gt_pass got v=%0h pc=%0h ir=%0h cp=%0h exp 1/200/c0000080/1", ir_valid, ir_pc, ir, cond_pass);
    end
`ifdef FETCH_SKIP_FAILED_EN
    nzcv = 4'b0100;
    #1;
    n_tests++; if (ir_valid !== 1'b0 || ir !== 32'h0) begin n_fail++; $display("FAIL cond_skip_hidden got v=%0h ir=%0h exp 0/0", ir_valid, ir); end
    step();
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL cond_skip_after_edge got v=%0h exp 0", ir_valid); end
    nzcv = 4'b1001;
    #1;
    n_tests++; if (ir_valid !== 1'b1 || cond_pass !== 1'b1) begin n_fail++; $display("FAIL cond_skip_nv got v=%0h cp=%0h exp 1/1", ir_valid, cond_pass); end
`else
    nzcv = 4'b0100;
    #1;
    n_tests++; if (cond_pass !== 1'b0 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL cond_gt_z got cp=%0h v=%0h exp 0/1", cond_pass, ir_valid); end
    nzcv = 4'b1000;
    #1;
    n_tests++; if (cond_pass !== 1'b0) begin n_fail++; $display("FAIL cond_gt_n_ne_v got cp=%0h exp 0", cond_pass); end
    nzcv = 4'b1001;
    #1;
    n_tests++; if (cond_pass !== 1'b1) begin n_fail++; $display("FAIL cond_gt_n_eq_v got cp=%0h exp 1", cond_pass); end
`endif
    nzcv = 4'b0000;
  endtask

  task automatic test_async_reset();
    ir_ready = 1'b1;
    step();
    step();
    step();
    n_tests++; if (fifo_count === 3'd0 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre got cnt=%0d v=%0h exp cnt>0 v=1", fifo_count, ir_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (ir_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL ar_immediate got v=%0h cnt=%0d exp 0/0", ir_valid, fifo_count); end
    n_tests++; if (mem_addr !== 32'h0 || mem_rd !== 1'b0 || ir_pc !== 32'h0) begin
      n_fail++; $display("FAIL ar_outputs got addr=%0h rd=%0h pc=%0h exp 0/0/0", mem_addr, mem_rd, ir_pc);
    end
    step();
    rst = 1'b0;
    step();
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL ar_restart_gap got v=%0h exp 0", ir_valid); end
    step();
    n_tests++; if (ir_valid !== 1'b1 || ir_pc !== 32'h0 || ir !== 32'hE000_0000) begin
      n_fail++; $display("FAIL ar_restart_head got v=%0h pc=%0h ir=%0h exp 1/0/e0000000", ir_valid, ir_pc, ir);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_same_edge_redirect_pop();
    test_redirect_flush();
    test_back_to_back_redirect();
    test_conditions();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
